// File: rtl/dot_product_pkg.sv
// Shared types and default sizing for the dot-product engine.
package dot_product_pkg;

    localparam int unsigned DEF_WIDTH     = 10;
    localparam int unsigned DEF_OUT_WIDTH = 20;
    localparam int unsigned DEF_VEC_LEN   = 8;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        DRAIN,
        OUTPUT
    } state_e;

endpackage

// File: rtl/dp_pair_buffer.sv
// Register file holding one vector pair: one write port, one registered read port.
module dp_pair_buffer
    import dot_product_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned VEC_LEN = DEF_VEC_LEN,
    parameter int unsigned ADDR_W  = $clog2(VEC_LEN)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [2*WIDTH-1:0]    wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [2*WIDTH-1:0]    rd_data
);

    logic [2*WIDTH-1:0] mem [VEC_LEN];

    // Storage is not reset; the controller never reads an unwritten slot.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dot_product_ctrl.sv
// Dot-product sequencer: buffers a vector pair, replays it through a MAC,
// and presents the result on a valid/ready port.
module dot_product_ctrl
    import dot_product_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int unsigned VEC_LEN   = DEF_VEC_LEN,
    parameter int unsigned ADDR_W    = $clog2(VEC_LEN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [WIDTH-1:0]     s_a,
    input  logic [WIDTH-1:0]     s_b,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 busy
);

    localparam int unsigned       PW      = 2 * WIDTH;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(VEC_LEN - 1);
    localparam logic [ADDR_W-1:0] OneIdx  = ADDR_W'(1);

    state_e                      state_q, state_d;
    logic [ADDR_W-1:0]           wr_idx_q, rd_idx_q;
    logic                        started_q, rd_vld_q;
    logic                        wr_en, rd_en;
    logic [PW-1:0]               rd_data;
    logic signed [PW-1:0]        op_a, op_b, prod;
    logic signed [OUT_WIDTH-1:0] prod_ext, acc_q, acc_next, m_data_q;
    logic                        m_valid_q;

    dp_pair_buffer #(
        .WIDTH  (WIDTH),
        .VEC_LEN(VEC_LEN),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(wr_idx_q),
        .wr_data({s_a, s_b}),
        .rd_en  (rd_en),
        .rd_addr(rd_idx_q),
        .rd_data(rd_data)
    );

    // Operands widened first so the multiply yields the full signed product.
    assign op_a     = PW'($signed(rd_data[PW-1:WIDTH]));
    assign op_b     = PW'($signed(rd_data[WIDTH-1:0]));
    assign prod     = op_a * op_b;
    // Size cast sign-extends or truncates to the accumulator width.
    assign prod_ext = OUT_WIDTH'(prod);
    assign acc_next = acc_q + prod_ext;

    // Next-state decode and buffer port strobes.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            LOAD: begin
                wr_en = s_valid;
                if (s_valid && wr_idx_q == LastIdx) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                // First COMPUTE cycle only clears the accumulator.
                rd_en = started_q;
                if (started_q && rd_idx_q == LastIdx) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = OUTPUT;
            end
            OUTPUT: begin
                if (m_ready) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Write/read index counters and compute-phase flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            started_q <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else begin
            rd_vld_q <= rd_en;
            if (wr_en) begin
                wr_idx_q <= (wr_idx_q == LastIdx) ? '0 : wr_idx_q + OneIdx;
            end
            if (rd_en) begin
                rd_idx_q <= (rd_idx_q == LastIdx) ? '0 : rd_idx_q + OneIdx;
            end
            if (state_q == COMPUTE) begin
                started_q <= 1'b1;
            end else begin
                started_q <= 1'b0;
            end
        end
    end

    // Accumulator and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else begin
            if (state_q == COMPUTE && !started_q) begin
                acc_q <= '0;
            end else if (rd_vld_q) begin
                acc_q <= acc_next;
            end
            if (state_q == DRAIN) begin
                m_data_q  <= acc_next;
                m_valid_q <= 1'b1;
            end else if (state_q == OUTPUT && m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign s_ready = (state_q == LOAD);
    assign busy    = (state_q == COMPUTE) || (state_q == OUTPUT);
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_dot_product_ctrl.sv
// Self-checking bench for dot_product_ctrl: table vectors, corner sequences
// and random vectors against a plain-arithmetic reference.
module tb_dot_product_ctrl;

    localparam int WIDTH     = 10;
    localparam int OUT_WIDTH = 20;
    localparam int VEC_LEN   = 8;
    localparam int LAT       = VEC_LEN + 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 s_valid;
    logic                 s_ready;
    logic [WIDTH-1:0]     s_a;
    logic [WIDTH-1:0]     s_b;
    logic                 m_valid;
    logic                 m_ready;
    logic [OUT_WIDTH-1:0] m_data;
    logic                 busy;

    int n_vec   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int acc_cyc = 0;

    typedef struct {
        int a0;
        int astep;
        int b;
        int gap;
        int hold;
        int exp;
    } vec_t;

    vec_t tbl[3];

    dot_product_ctrl #(
        .WIDTH    (WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .VEC_LEN  (VEC_LEN)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_a    (s_a),
        .s_b    (s_b),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .busy   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sum of products wrapped to a signed OUT_WIDTH-bit value.
    function automatic int dot_ref(input int a[VEC_LEN], input int b[VEC_LEN]);
        longint s = 0;
        longint m = longint'(1) << OUT_WIDTH;
        for (int i = 0; i < VEC_LEN; i++) s += longint'(a[i]) * longint'(b[i]);
        s = s % m;
        if (s < 0) s += m;
        if (s >= m / 2) s -= m;
        return int'(s);
    endfunction

    task automatic chk_idle(input string name);
        chk({name, "_s_ready"}, int'(s_ready), 1);
        chk({name, "_m_valid"}, int'(m_valid), 0);
        chk({name, "_m_data"}, $signed(m_data), 0);
        chk({name, "_busy"}, int'(busy), 0);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    // Feeds up to cnt pairs with up to gap_max idle cycles (junk data) before each.
    task automatic send_pairs(input int a[VEC_LEN], input int b[VEC_LEN], input int cnt,
                              input int gap_max);
        int t;
        t = 0;
        while (!s_ready && t < 50) begin
            step();
            t++;
        end
        for (int i = 0; i < cnt; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            s_valid = 1'b0;
            s_a = WIDTH'($urandom);
            s_b = WIDTH'($urandom);
            repeat (g) step();
            s_valid = 1'b1;
            s_a = WIDTH'(a[i]);
            s_b = WIDTH'(b[i]);
            chk("s_ready_in_load", int'(s_ready), 1);
            step();
        end
        s_valid = 1'b0;
        acc_cyc = cyc;
    endtask

    task automatic send_vector(input int a[VEC_LEN], input int b[VEC_LEN], input int gap_max);
        send_pairs(a, b, VEC_LEN, gap_max);
        chk("s_ready_after_last", int'(s_ready), 0);
        chk("busy_compute", int'(busy), 1);
    endtask

    // Waits for the result, checks latency/value, optionally stalls the consumer.
    task automatic get_result(input int exp, input int hold, input string name);
        int t;
        t = 0;
        m_ready = (hold == 0);
        while (!m_valid && t < 50) begin
            step();
            t++;
        end
        chk({name, "_m_valid_seen"}, int'(m_valid), 1);
        chk({name, "_latency"}, cyc - acc_cyc, LAT);
        chk({name, "_m_data"}, $signed(m_data), exp);
        chk({name, "_s_ready_out"}, int'(s_ready), 0);
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                s_valid = 1'b1;
                s_a = WIDTH'($urandom);
                s_b = WIDTH'($urandom);
                step();
                chk({name, "_hold_m_valid"}, int'(m_valid), 1);
                chk({name, "_hold_m_data"}, $signed(m_data), exp);
                chk({name, "_hold_s_ready"}, int'(s_ready), 0);
                chk({name, "_hold_busy"}, int'(busy), 1);
            end
            s_valid = 1'b0;
            m_ready = 1'b1;
        end
        step();
        chk({name, "_m_valid_drop"}, int'(m_valid), 0);
        chk({name, "_s_ready_back"}, int'(s_ready), 1);
        chk({name, "_busy_back"}, int'(busy), 0);
    endtask

    initial begin
        int a[VEC_LEN];
        int b[VEC_LEN];
        int e;

        tbl[0] = '{a0: 1,   astep: 1, b: 1,   gap: 0, hold: 0, exp: 36};
        tbl[1] = '{a0: -3,  astep: 0, b: 5,   gap: 3, hold: 0, exp: -120};
        tbl[2] = '{a0: 511, astep: 0, b: 511, gap: 0, hold: 5, exp: -8184};

        reset   = 1'b1;
        s_valid = 1'b0;
        s_a     = '0;
        s_b     = '0;
        m_ready = 1'b0;
        do_reset(2);
        chk_idle("reset");

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                a[i] = tbl[k].a0 + tbl[k].astep * i;
                b[i] = tbl[k].b;
            end
            send_vector(a, b, tbl[k].gap);
            get_result(tbl[k].exp, tbl[k].hold, $sformatf("tbl%0d", k));
        end

        // Abort a partially loaded vector; the next one must start at index 0.
        for (int i = 0; i < VEC_LEN; i++) begin
            a[i] = 100;
            b[i] = 100;
        end
        send_pairs(a, b, 3, 0);
        do_reset(1);
        chk_idle("abort_load");
        for (int i = 0; i < VEC_LEN; i++) begin
            a[i] = 2;
            b[i] = 3;
        end
        send_vector(a, b, 0);
        get_result(48, 0, "after_abort");

        // Reset while a result is pending discards it.
        for (int i = 0; i < VEC_LEN; i++) begin
            a[i] = 7;
            b[i] = -9;
        end
        send_vector(a, b, 1);
        m_ready = 1'b0;
        repeat (LAT + 1) step();
        chk("pending_m_valid", int'(m_valid), 1);
        do_reset(1);
        chk_idle("abort_output");

        // Random vectors against the reference model.
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < VEC_LEN; i++) begin
                a[i] = int'($urandom_range(0, 1023)) - 512;
                b[i] = int'($urandom_range(0, 1023)) - 512;
            end
            e = dot_ref(a, b);
            send_vector(a, b, int'($urandom_range(0, 2)));
            get_result(e, int'($urandom_range(0, 3)), $sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
